// File: rtl/rtype_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for R-type instructions. Takes 4 cycles per instruction
// plus one per fetch wait cycle. Holds imem_req until ack; an illegal opcode or a fetch timeout halts it (sticky).
module rtype_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CNT_W     = 32,
   parameter int          FETCH_TMO = 255
) (
   input  logic             clock,
   input  logic             reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   output logic [4:0]       rd_addr,
   output logic [3:0]       alu_control,
   output logic             rf_we,
   output logic [31:0]      pc,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic [1:0]       err_code
);

   localparam int             TMO_W    = $clog2(FETCH_TMO + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TMO - 1);
   localparam logic [6:0]     OP_RTYPE = 7'b0110011;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      ir;
   logic [TMO_W-1:0] tmo_cnt;
   logic             fetch_take;
   logic             tmo_hit;
   logic             dec_ok;
   logic [3:0]       dec_alu;

   assign imem_addr = pc;
   assign rs1_addr  = ir[19:15];
   assign rs2_addr  = ir[24:20];
   assign rd_addr   = ir[11:7];

   // Decode is legal only for the R-type opcode and an exact funct7 match.
   always_comb begin
      dec_ok  = 1'b0;
      dec_alu = 4'b0000;
      if (ir[6:0] == OP_RTYPE) begin
         case (ir[14:12])
            3'd0: begin
               if (ir[31:25] == 7'h00) begin dec_ok = 1'b1; dec_alu = 4'b0010; end
               else if (ir[31:25] == 7'h20) begin dec_ok = 1'b1; dec_alu = 4'b0100; end
            end
            3'd1: if (ir[31:25] == 7'h00) begin dec_ok = 1'b1; dec_alu = 4'b0011; end
            3'd2: if (ir[31:25] == 7'h00) begin dec_ok = 1'b1; dec_alu = 4'b1000; end
            3'd3: if (ir[31:25] == 7'h00) begin dec_ok = 1'b1; dec_alu = 4'b1001; end
            3'd4: if (ir[31:25] == 7'h00) begin dec_ok = 1'b1; dec_alu = 4'b0111; end
            3'd5: begin
               if (ir[31:25] == 7'h00) begin dec_ok = 1'b1; dec_alu = 4'b0101; end
               else if (ir[31:25] == 7'h20) begin dec_ok = 1'b1; dec_alu = 4'b1010; end
            end
            3'd6: if (ir[31:25] == 7'h00) begin dec_ok = 1'b1; dec_alu = 4'b0001; end
            default: if (ir[31:25] == 7'h00) begin dec_ok = 1'b1; dec_alu = 4'b0000; end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      fetch_take = 1'b0;
      tmo_hit    = 1'b0;
      rf_we      = 1'b0;
      halted     = 1'b0;
      case (state)
         S_FETCH: begin
            if (imem_req && imem_ack) begin
               fetch_take = 1'b1;
               state_nxt  = S_DECODE;
            end else if (imem_req && (tmo_cnt == TMO_LAST)) begin
               tmo_hit   = 1'b1;
               state_nxt = S_HALT;
            end
         end
         S_DECODE: state_nxt = dec_ok ? S_EXEC : S_HALT;
         S_EXEC:   state_nxt = S_WB;
         S_WB: begin
            // Writes to x0 are suppressed but the instruction still retires.
            rf_we     = (ir[11:7] != 5'd0);
            state_nxt = S_FETCH;
         end
         S_HALT:   halted = 1'b1;
         default:  state_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc          <= RESET_PC;
         ir          <= 32'h0;
         alu_control <= 4'b0000;
         imem_req    <= 1'b0;
         retired     <= '0;
         err_code    <= 2'b00;
         tmo_cnt     <= '0;
      end else begin
         // Registered request: rises one cycle after reset, drops the cycle after ack.
         imem_req <= (state_nxt == S_FETCH);
         if (state == S_FETCH && imem_req)
            tmo_cnt <= fetch_take ? '0 : tmo_cnt + 1'b1;
         if (fetch_take)
            ir <= imem_rdata;
         if (state == S_DECODE) begin
            if (dec_ok) alu_control <= dec_alu;
            else        err_code    <= 2'b01;
         end
         if (tmo_hit)
            err_code <= 2'b10;
         if (state == S_WB) begin
            pc      <= pc + 32'd4;
            retired <= retired + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Directed bench for rtype_sequencer: hand-encoded instructions with a scripted imem handshake.
module tb_rtype_sequencer;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
   localparam int          TMO    = 6;
   localparam logic [6:0]  OP_R   = 7'b0110011;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [3:0]  alu_control;
   logic        rf_we;
   logic [31:0] pc;
   logic [31:0] retired;
   logic        halted;
   logic [1:0]  err_code;

   int n_chk = 0, n_pass = 0, cyc = 0, we_cnt = 0;

   rtype_sequencer #(.RESET_PC(RST_PC), .CNT_W(32), .FETCH_TMO(TMO)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .alu_control(alu_control), .rf_we(rf_we), .pc(pc), .retired(retired),
      .halted(halted), .err_code(err_code)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (rf_we === 1'b1) we_cnt <= we_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      imem_ack = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Waits (bounded) for imem_req, holds off ack for dly cycles, then acks with w.
   task automatic do_fetch(input logic [31:0] w, input int dly, input logic [31:0] exp_addr);
      int n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      check("req_rise", imem_req, 1);
      check("fetch_addr", imem_addr, exp_addr);
      for (int i = 0; i < dly; i++) begin
         step();
         check("req_hold", imem_req, 1);
         check("addr_stable", imem_addr, exp_addr);
      end
      imem_ack   = 1'b1;
      imem_rdata = w;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check("req_drop", imem_req, 0);
   endtask

   task automatic run_legal(input logic [31:0] w, input int dly, input logic [31:0] exp_pc,
                            input logic [3:0] exp_alu, input logic exp_we);
      do_fetch(w, dly, exp_pc);
      step();
      check("exec_alu", alu_control, exp_alu);
      check("exec_no_we", rf_we, 0);
      step();
      check("wb_we", rf_we, exp_we);
      step();
      check("next_pc", pc, exp_pc + 32'd4);
   endtask

   typedef struct {
      logic [2:0] f3;
      logic [6:0] f7;
      logic [3:0] alu;
   } dec_vec_t;

   dec_vec_t dec_tab [10] = '{
      '{3'd0, 7'h00, 4'b0010}, '{3'd0, 7'h20, 4'b0100}, '{3'd1, 7'h00, 4'b0011},
      '{3'd2, 7'h00, 4'b1000}, '{3'd3, 7'h00, 4'b1001}, '{3'd4, 7'h00, 4'b0111},
      '{3'd5, 7'h00, 4'b0101}, '{3'd5, 7'h20, 4'b1010}, '{3'd6, 7'h00, 4'b0001},
      '{3'd7, 7'h00, 4'b0000}
   };

   initial begin
      int t1, t2, c0, we0;
      logic [31:0] exp_pc;

      // 1: reset state, ack ignored while req low, add x3,x1,x2
      reset = 1'b1;
      step();
      step();
      check("rst_pc", pc, RST_PC);
      check("rst_req", imem_req, 0);
      check("rst_retired", retired, 0);
      check("rst_halted", halted, 0);
      check("rst_err", err_code, 0);
      check("rst_we", rf_we, 0);
      check("rst_alu", alu_control, 0);
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h0000_0093;
      step();
      imem_ack = 1'b0;
      check("req_after_rst", imem_req, 1);
      check("ack_ignored", halted, 0);
      do_fetch(32'h0020_81B3, 0, RST_PC);
      check("dec_rs1", rs1_addr, 1);
      check("dec_rs2", rs2_addr, 2);
      check("dec_rd", rd_addr, 3);
      step();
      check("add_alu", alu_control, 4'b0010);
      check("add_exec_we", rf_we, 0);
      step();
      check("add_wb_we", rf_we, 1);
      step();
      check("add_we_drop", rf_we, 0);
      check("add_pc", pc, 32'hFFFF_FFFC);
      check("add_retired", retired, 1);

      // 2: sub then sra back-to-back, pc wraps through zero
      do_reset();
      do_fetch(32'h4020_81B3, 0, RST_PC);
      step();
      check("sub_alu", alu_control, 4'b0100);
      step();
      check("sub_we", rf_we, 1);
      t1 = cyc;
      step();
      do_fetch(32'h4020_D1B3, 0, 32'hFFFF_FFFC);
      step();
      check("sra_alu", alu_control, 4'b1010);
      step();
      check("sra_we", rf_we, 1);
      t2 = cyc;
      check("we_spacing", t2 - t1, 4);
      step();
      check("wrap_pc", pc, 32'h0000_0000);
      check("b2b_retired", retired, 2);

      // 3: ack delayed by 3 cycles, 7 cycles total
      do_reset();
      step();
      c0 = cyc;
      run_legal(32'h0020_81B3, 3, RST_PC, 4'b0010, 1'b1);
      check("delay_total", cyc - c0, 7);

      // decode table, back-to-back, rd=5
      do_reset();
      exp_pc = RST_PC;
      for (int i = 0; i < 10; i++) begin
         run_legal({dec_tab[i].f7, 5'd2, 5'd1, dec_tab[i].f3, 5'd5, OP_R}, i % 2, exp_pc,
                   dec_tab[i].alu, 1'b1);
         exp_pc = exp_pc + 32'd4;
      end
      check("tab_retired", retired, 10);

      // 4: illegal opcode and illegal funct7
      do_reset();
      we0 = we_cnt;
      do_fetch(32'h0000_0093, 0, RST_PC);
      step();
      check("ill_halted", halted, 1);
      check("ill_err", err_code, 2'b01);
      check("ill_req", imem_req, 0);
      imem_ack = 1'b1;
      repeat (3) step();
      imem_ack = 1'b0;
      check("ill_sticky", halted, 1);
      check("ill_pc", pc, RST_PC);
      check("ill_retired", retired, 0);
      check("ill_no_we", we_cnt - we0, 0);
      do_reset();
      do_fetch(32'h0220_81B3, 0, RST_PC);
      step();
      check("f7_1_err", err_code, 2'b01);
      do_reset();
      do_fetch({7'h20, 5'd2, 5'd1, 3'd1, 5'd5, OP_R}, 0, RST_PC);
      step();
      check("sll_f7_err", err_code, 2'b01);

      // 5: fetch timeout after one good instruction
      do_reset();
      run_legal(32'h0020_81B3, 0, RST_PC, 4'b0010, 1'b1);
      for (int i = 1; i < TMO; i++) step();
      check("tmo_edge_nohalt", halted, 0);
      check("tmo_edge_req", imem_req, 1);
      step();
      check("tmo_halted", halted, 1);
      check("tmo_err", err_code, 2'b10);
      check("tmo_req", imem_req, 0);
      check("tmo_pc", pc, 32'hFFFF_FFFC);
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("tmo_frozen_err", err_code, 2'b10);
      check("tmo_frozen_ret", retired, 1);
      do_reset();
      check("tmo_rst_pc", pc, RST_PC);
      check("tmo_rst_halt", halted, 0);
      check("tmo_rst_err", err_code, 0);

      // 6: rd=0 retires without a write; reset during EXEC abandons the instruction
      do_reset();
      we0 = we_cnt;
      do_fetch(32'h0020_8033, 0, RST_PC);
      check("rd0_rd", rd_addr, 0);
      step();
      step();
      check("rd0_wb_we", rf_we, 0);
      step();
      check("rd0_retired", retired, 1);
      check("rd0_no_we", we_cnt - we0, 0);
      do_fetch(32'h0020_81B3, 0, 32'hFFFF_FFFC);
      step();
      reset = 1'b1;
      step();
      check("exec_rst_we", rf_we, 0);
      check("exec_rst_pc", pc, RST_PC);
      check("exec_rst_ret", retired, 0);
      reset = 1'b0;
      step();
      check("exec_rst_no_we", we_cnt - we0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
